csr_trap_ctrl: RTL

- Sequences machine-mode trap entry and MRET return through the single-port CSR write interface of CSR_Unit. Sits between pipeline control and CSR_Unit.
- Arbitrates between a synchronous exception, the three machine interrupt lines and MRET.
- Issues one CSR write per cycle, then a single-cycle PC redirect.
- Holds MPIE internally, because CSR_Unit implements only mstatus.MIE.

---
 rtl/csr_trap_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
// Sequences machine-mode trap entry and MRET return through the single-port
// CSR write interface of CSR_Unit.
//
// In IDLE it arbitrates, one winner per cycle, in this order:
//   1. synchronous exception
//   2. enabled machine interrupt (MEI, then MSI, then MTI)
//   3. MRET
//
// A trap writes mepc, then mcause, then mstatus, one write per cycle, and is
// followed by a single-cycle PC redirect. MRET writes mstatus and then
// redirects to mepc. MPIE is held here because CSR_Unit implements only
// mstatus.MIE.
//
// Handshake: each request is a level held by the requester until its ack
// pulse. An ack is a single-cycle pulse, given only in IDLE and only while
// out of reset. While busy_o is high no request is accepted; pending
// requests are re-arbitrated in the next IDLE cycle.
//
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   exc_valid_i/exc_cause_i/exc_pc_i     exception request, cause, faulting PC
//   irq_ext_i/irq_sw_i/irq_timer_i       level-sensitive interrupt lines
//   pc_i                                 interrupt return address
//   mret_i                               MRET request
//   mstatus_mie_i, mie_i, mtvec_i,
//   mepc_i                               current CSR values from CSR_Unit
//   exc_ack_o/irq_ack_o/mret_ack_o       acceptance pulses
//   busy_o                               sequence in progress (pipeline stall)
//   csr_we_o/csr_addr_o/csr_data_o/
//   csr_op_o                             CSR write port (op is always CSRRW)
//   mpie_o                               current MPIE
//   redirect_valid_o/redirect_pc_o       single-cycle PC redirect
module csr_trap_ctrl #(
    parameter bit          VECTORED_EN  = 1'b1,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic [31:0] pc_i,
    input  logic        mret_i,
    input  logic        mstatus_mie_i,
    input  logic [2:0]  mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        exc_ack_o,
    output logic        irq_ack_o,
    output logic        mret_ack_o,
    output logic        busy_o,
    output logic        csr_we_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_data_o,
    output logic [1:0]  csr_op_o,
    output logic        mpie_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STATUS,
        S_REDIRECT,
        S_R_STATUS,
        S_R_REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cause_q, cause_d;
    logic        intr_q, intr_d;
    logic [31:0] ret_pc_q, ret_pc_d;
    logic        mpie_q, mpie_d;

    // mie_i is {MEIE, MTIE, MSIE}
    logic mei_pend, msi_pend, mti_pend, irq_take;
    assign mei_pend = irq_ext_i   & mie_i[2];
    assign msi_pend = irq_sw_i    & mie_i[0];
    assign mti_pend = irq_timer_i & mie_i[1];
    assign irq_take = mstatus_mie_i & (mei_pend | msi_pend | mti_pend);

    logic [31:0] trap_base;
    logic        vec_mode;
    assign trap_base = {mtvec_i[31:2], 2'b00};
    assign vec_mode  = VECTORED_EN && (mtvec_i[1:0] == 2'b01) && intr_q;

    assign csr_op_o = 2'b01;
    assign mpie_o   = mpie_q;
    assign busy_o   = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cause_q  <= 4'd0;
            intr_q   <= 1'b0;
            ret_pc_q <= 32'd0;
            mpie_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            intr_q   <= intr_d;
            ret_pc_q <= ret_pc_d;
            mpie_q   <= mpie_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        intr_d           = intr_q;
        ret_pc_d         = ret_pc_q;
        mpie_d           = mpie_q;
        exc_ack_o        = 1'b0;
        irq_ack_o        = 1'b0;
        mret_ack_o       = 1'b0;
        csr_we_o         = 1'b0;
        csr_addr_o       = 12'd0;
        csr_data_o       = 32'd0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;

        case (state_q)
            S_IDLE: begin
                // The FSM sits in IDLE during reset; keep the acks quiet there.
                if (rst_ni) begin
                    if (exc_valid_i) begin
                        exc_ack_o = 1'b1;
                        cause_d   = exc_cause_i;
                        intr_d    = 1'b0;
                        ret_pc_d  = exc_pc_i;
                        state_d   = S_W_EPC;
                    end else if (irq_take) begin
                        irq_ack_o = 1'b1;
                        intr_d    = 1'b1;
                        ret_pc_d  = pc_i;
                        if (mei_pend)      cause_d = 4'd11;
                        else if (msi_pend) cause_d = 4'd3;
                        else               cause_d = 4'd7;
                        state_d   = S_W_EPC;
                    end else if (mret_i) begin
                        mret_ack_o = 1'b1;
                        state_d    = S_R_STATUS;
                    end
                end
            end
            S_W_EPC: begin
                csr_we_o   = 1'b1;
                csr_addr_o = MEPC_ADDR;
                csr_data_o = ret_pc_q & 32'hFFFF_FFFE;
                state_d    = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                csr_we_o   = 1'b1;
                csr_addr_o = MCAUSE_ADDR;
                csr_data_o = {intr_q, 27'd0, cause_q};
                state_d    = S_W_STATUS;
            end
            S_W_STATUS: begin
                // MIE cleared, MPIE (bit 7) takes the MIE value seen now.
                csr_we_o   = 1'b1;
                csr_addr_o = MSTATUS_ADDR;
                csr_data_o = {24'd0, mstatus_mie_i, 3'd0, 1'b0, 3'd0};
                mpie_d     = mstatus_mie_i;
                state_d    = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = vec_mode ? (trap_base + {26'd0, cause_q, 2'b00})
                                            : trap_base;
                state_d          = S_IDLE;
            end
            S_R_STATUS: begin
                // MIE restored from MPIE, MPIE set to 1.
                csr_we_o   = 1'b1;
                csr_addr_o = MSTATUS_ADDR;
                csr_data_o = {24'd0, 1'b1, 3'd0, mpie_q, 3'd0};
                mpie_d     = 1'b1;
                state_d    = S_R_REDIRECT;
            end
            S_R_REDIRECT: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mepc_i & 32'hFFFF_FFFE;
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
